// File: rtl/fir_mac_param.sv
// rtl/fir_mac_param.sv - parametrised time-multiplexed FIR MAC core with shadow/active coefficient banks
module fir_mac_param #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int N_TAPS    = 8,
  parameter int OUT_SHIFT = 15,
  parameter int SATURATE  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_W-1:0]                 i_data,
  input  logic                              i_valid,
  output logic                              o_ready,
  output logic [DATA_W-1:0]                 o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  input  logic                              coef_we,
  input  logic [$clog2(N_TAPS)-1:0]         coef_addr,
  input  logic [COEF_W-1:0]                 coef_wdata
);

  localparam int AW    = $clog2(N_TAPS);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(N_TAPS);
  localparam int PW    = DATA_W + COEF_W;

  localparam logic [AW:0]   TAP_LIMIT = (AW+1)'(N_TAPS);
  localparam logic [AW-1:0] LAST_TAP  = AW'(N_TAPS - 1);

  // Output clamp bounds expressed at accumulator width so the comparison is exact
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state;

  logic signed [DATA_W-1:0] x_dly        [N_TAPS];
  logic signed [COEF_W-1:0] c_shadow     [N_TAPS];
  logic signed [COEF_W-1:0] c_shadow_nxt [N_TAPS];
  logic signed [COEF_W-1:0] c_active     [N_TAPS];

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [PW-1:0]     prod;
  logic [AW-1:0]            tap;
  logic [DATA_W-1:0]        data_fmt;
  logic                     accept;
  logic                     wr_ok;

  assign accept = (state == S_IDLE) && o_ready && i_valid;

  // Writes to tap indices beyond the filter length are dropped
  assign wr_ok = coef_we && ({1'b0, coef_addr} < TAP_LIMIT);

  // Next shadow bank: also the value loaded into the active bank on accept, so a
  // write landing in the accept cycle already applies to that sample
  always_comb begin
    for (int k = 0; k < N_TAPS; k++) begin
      c_shadow_nxt[k] = c_shadow[k];
    end
    if (wr_ok) begin
      c_shadow_nxt[coef_addr] = coef_wdata;
    end
  end

  // One full-precision product per cycle, sign-extended into the accumulator
  always_comb begin
    prod    = x_dly[tap] * c_active[tap];
    acc_sum = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    acc_shr = acc_sum >>> OUT_SHIFT;
  end

  // Output scaling: clamp to the sample range or keep the low bits
  always_comb begin
    data_fmt = acc_shr[DATA_W-1:0];
    if (SATURATE != 0) begin
      if (acc_shr > SAT_MAX) begin
        data_fmt = SAT_MAX[DATA_W-1:0];
      end else if (acc_shr < SAT_MIN) begin
        data_fmt = SAT_MIN[DATA_W-1:0];
      end
    end
  end

  // Shadow bank tracks every write regardless of FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        c_shadow[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_TAPS; k++) begin
        c_shadow[k] <= c_shadow_nxt[k];
      end
    end
  end

  // Delay line and active bank advance only when a sample is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        x_dly[k]    <= '0;
        c_active[k] <= '0;
      end
    end else if (accept) begin
      x_dly[0] <= i_data;
      for (int k = 1; k < N_TAPS; k++) begin
        x_dly[k] <= x_dly[k-1];
      end
      for (int k = 0; k < N_TAPS; k++) begin
        c_active[k] <= c_shadow_nxt[k];
      end
    end
  end

  // Control FSM: accept a sample, run N_TAPS MAC cycles, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      acc     <= '0;
      tap     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc     <= '0;
            tap     <= '0;
            o_ready <= 1'b0;
            state   <= S_MAC;
          end else begin
            o_ready <= 1'b1;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          tap <= tap + 1'b1;
          if (tap == LAST_TAP) begin
            o_valid <= 1'b1;
            o_data  <= data_fmt;
            state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ready <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_ready <= 1'b0;
          o_valid <= 1'b0;
          o_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_param.sv
// tb/tb_fir_mac_param.sv - self-checking bench for fir_mac_param
module tb_fir_mac_param;

  localparam int N  = 8;
  localparam int N6 = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_data;
  logic        i_valid, i_ready, coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        o_ready, o_valid;
  logic [15:0] o_data;
  logic        w_ready, w_valid;
  logic [15:0] w_data;

  logic [15:0] d6_i_data, d6_wdata, d6_o_data;
  logic        d6_i_valid, d6_i_ready, d6_we, d6_o_ready, d6_o_valid;
  logic [2:0]  d6_addr;

  always #5 clk = ~clk;

  fir_mac_param dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata)
  );

  fir_mac_param #(.SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(w_ready),
    .o_data(w_data), .o_valid(w_valid), .i_ready(i_ready), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata)
  );

  fir_mac_param #(.N_TAPS(N6)) dut6 (
    .clk(clk), .rst_n(rst_n), .i_data(d6_i_data), .i_valid(d6_i_valid), .o_ready(d6_o_ready),
    .o_data(d6_o_data), .o_valid(d6_o_valid), .i_ready(d6_i_ready), .coef_we(d6_we),
    .coef_addr(d6_addr), .coef_wdata(d6_wdata)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;

  int hist     [N];
  int shadow_m [N];
  int active_m [N];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_out(input bit sat);
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(hist[k]) * longint'(active_m[k]);
    s = s >>> 15;
    if (sat) begin
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
    end
    return 16'(s);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      hist[k] = 0; shadow_m[k] = 0; active_m[k] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic set_coef(input logic [2:0] a, input logic [15:0] v);
    coef_we = 1'b1; coef_addr = a; coef_wdata = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
    shadow_m[a] = int'($signed(v));
  endtask

  // Accept one sample, optionally write a coefficient at accept (we_at=0) or
  // we_at edges later, optionally stall the output for 'hold' cycles.
  task automatic feed(input string name, input logic [15:0] x, input int we_at,
                      input logic [2:0] wa, input logic [15:0] wv, input int hold,
                      output logic [15:0] got, output logic [15:0] got_w);
    int n;
    logic [15:0] exp_s, exp_w;
    i_data = x; i_valid = 1'b1; n = 0;
    while (!o_ready && n < 40) begin @(posedge clk); #1; n++; end
    if (n >= 40) check({name, " ready_timeout"}, 32'(n), 32'(0));
    if (we_at == 0) begin coef_we = 1'b1; coef_addr = wa; coef_wdata = wv; end
    @(posedge clk); #1;
    last_acc = cyc;
    i_valid = 1'b0; coef_we = 1'b0;
    if (we_at == 0) shadow_m[wa] = int'($signed(wv));
    for (int k = N-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'($signed(x));
    for (int k = 0; k < N; k++) active_m[k] = shadow_m[k];
    exp_s = model_out(1'b1);
    exp_w = model_out(1'b0);
    i_ready = (hold == 0);
    n = 0;
    while (!o_valid && n < 40) begin
      if (we_at > 0 && n == we_at - 1) begin coef_we = 1'b1; coef_addr = wa; coef_wdata = wv; end
      @(posedge clk); #1; n++;
      if (coef_we) begin coef_we = 1'b0; shadow_m[wa] = int'($signed(wv)); end
    end
    check({name, " latency"}, 32'(n), 32'(N));
    got = o_data; got_w = w_data;
    check({name, " data"}, {16'h0, o_data}, {16'h0, exp_s});
    check({name, " wrap_data"}, {16'h0, w_data}, {16'h0, exp_w});
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'b1; i_data = ~x;
      @(posedge clk); #1;
      check({name, " hold_data"}, {16'h0, o_data}, {16'h0, got});
      check({name, " hold_valid_ready"}, {30'h0, o_valid, o_ready}, 32'h2);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " post_hs"}, {14'h0, o_valid, o_ready, o_data}, 32'h0001_0000);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] exp;
  } vec_t;

  vec_t imp [8];

  initial begin : main
    logic [15:0] got, got_w, first;
    int prev;
    rst_n = 1'b0; i_data = '0; i_valid = 1'b0; i_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    d6_i_data = '0; d6_i_valid = 1'b0; d6_i_ready = 1'b1; d6_we = 1'b0; d6_addr = '0; d6_wdata = '0;
    model_reset();

    for (int i = 0; i < 8; i++) begin
      imp[i].x   = (i == 0) ? 16'h4000 : 16'h0000;
      imp[i].exp = 16'(16'h0400 * (i + 1));
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {15'h0, o_ready, o_valid, o_data}, 32'h0);
    check("reset_outputs6", {15'h0, d6_o_ready, d6_o_valid, d6_o_data}, 32'h0);
    rst_n = 1'b1;
    check("ready_before_edge", {31'h0, o_ready}, 32'h0);
    @(posedge clk); #1;
    check("ready_first_edge", {31'h0, o_ready}, 32'h1);

    // impulse response, table-driven
    for (int k = 0; k < 8; k++) set_coef(3'(k), 16'(16'h0800 * (k + 1)));
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      feed("impulse", imp[i].x, -1, 3'd0, 16'h0, 0, got, got_w);
      check("impulse_table", {16'h0, got}, {16'h0, imp[i].exp});
      if (i > 0) check("accept_gap", 32'(last_acc - prev), 32'(N + 2));
      prev = last_acc;
    end

    // saturation, positive; wrap instance sees same data
    do_reset();
    for (int k = 0; k < 8; k++) set_coef(3'(k), 16'h7FFF);
    for (int i = 0; i < 8; i++) begin
      feed("sat_pos", 16'h7FFF, -1, 3'd0, 16'h0, 0, got, got_w);
      if (i == 0) first = got;
    end
    check("sat_pos_first", {16'h0, first}, 32'h7FFE);
    check("sat_pos_last", {16'h0, got}, 32'h7FFF);
    check("wrap_pos_last", {16'h0, got_w}, 32'hFFF0);

    // saturation, negative
    do_reset();
    for (int k = 0; k < 8; k++) set_coef(3'(k), 16'h7FFF);
    for (int i = 0; i < 8; i++) feed("sat_neg", 16'h8000, -1, 3'd0, 16'h0, 0, got, got_w);
    check("sat_neg_last", {16'h0, got}, 32'h8000);

    // coefficient bank: write in accept cycle, write during MAC, backpressure
    do_reset();
    feed("coef_bypass", 16'h4000, 0, 3'd0, 16'h7FFF, 0, got, got_w);
    check("coef_bypass_val", {16'h0, got}, 32'h3FFF);
    feed("coef_mac_wr", 16'h4000, 2, 3'd0, 16'h0000, 0, got, got_w);
    check("coef_mac_wr_val", {16'h0, got}, 32'h3FFF);
    feed("coef_next", 16'h4000, -1, 3'd0, 16'h0, 5, got, got_w);
    check("coef_next_val", {16'h0, got}, 32'h0);

    // reset in the middle of MAC
    set_coef(3'd1, 16'h4000);
    i_data = 16'h4000; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midmac_reset", {15'h0, o_ready, o_valid, o_data}, 32'h0);
    repeat (2) @(posedge clk);
    #1 check("midmac_reset_hold", {15'h0, o_ready, o_valid, o_data}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midmac_ready_back", {31'h0, o_ready}, 32'h1);
    model_reset();
    feed("after_reset", 16'h4000, -1, 3'd0, 16'h0, 0, got, got_w);
    check("after_reset_val", {16'h0, got}, 32'h0);

    // randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      int we_at, hold;
      if ($urandom_range(0, 2) == 0) set_coef(3'($urandom_range(0, 7)), 16'($urandom));
      we_at = int'($urandom_range(0, 6)) - 1;
      hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      feed("random", 16'($urandom), we_at, 3'($urandom_range(0, 7)), 16'($urandom), hold, got, got_w);
    end

    // six-tap instance: out-of-range addresses are dropped
    do_reset();
    d6_we = 1'b1;
    d6_addr = 3'd6; d6_wdata = 16'h7FFF; @(posedge clk); #1;
    d6_addr = 3'd7; d6_wdata = 16'h7FFF; @(posedge clk); #1;
    d6_addr = 3'd5; d6_wdata = 16'h0800; @(posedge clk); #1;
    d6_we = 1'b0;
    for (int i = 0; i < N6; i++) begin
      int n;
      d6_i_data = (i == 0) ? 16'h4000 : 16'h0000;
      d6_i_valid = 1'b1; n = 0;
      while (!d6_o_ready && n < 40) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      d6_i_valid = 1'b0; n = 0;
      while (!d6_o_valid && n < 40) begin @(posedge clk); #1; n++; end
      check("tap6_latency", 32'(n), 32'(N6));
      check("tap6_data", {16'h0, d6_o_data}, (i == N6 - 1) ? 32'h0400 : 32'h0);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
